// File: rtl/serial_adder_decoder_if.sv
// Request/result bundle for serial_adder_decoder: operands and start in, status and result out.
interface serial_adder_decoder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C;
  logic             V;

  modport master (
    output start, A, B, Cin, Sub,
    input  busy, done, S, C, V
  );

  modport slave (
    input  start, A, B, Cin, Sub,
    output busy, done, S, C, V
  );
endinterface

// File: rtl/serial_adder_decoder.sv
// Bit-serial WIDTH-bit adder built on a 3-to-8 minterm decoder cell, one bit per clock.
// Optional macro SERIAL_ADDER_SUB_EN enables subtraction (A + ~B + 1) selected by Sub.
module serial_adder_decoder #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_adder_decoder_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] decode3to8(input logic [2:0] sel);
    logic [7:0] d;
    d = 8'd1 << sel;
    return d;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] a_r, a_nxt_s;
  logic [WIDTH-1:0] b_r, b_nxt_s;
  logic [WIDTH-1:0] work_r, work_nxt_s;
  logic             carry_r, carry_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [WIDTH-1:0] s_r, s_nxt_s;
  logic             c_r, c_nxt_s;
  logic             v_r, v_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;

  logic [7:0]       dec_s;
  logic             sum_s;
  logic             cout_s;
  logic [WIDTH-1:0] b_load_s;
  logic             c_load_s;

  // Decoder cell and operand conditioning for the accept cycle
  always_comb begin
    dec_s  = decode3to8({a_r[0], b_r[0], carry_r});
    sum_s  = dec_s[1] | dec_s[2] | dec_s[4] | dec_s[7];
    cout_s = dec_s[3] | dec_s[5] | dec_s[6] | dec_s[7];
`ifdef SERIAL_ADDER_SUB_EN
    if (bus.Sub) begin
      b_load_s = ~bus.B;
      c_load_s = 1'b1;
    end else begin
      b_load_s = bus.B;
      c_load_s = bus.Cin;
    end
`else
    b_load_s = bus.B;
    c_load_s = bus.Cin;
`endif
  end

`ifndef SERIAL_ADDER_SUB_EN
  logic unused_sub_s;
  assign unused_sub_s = bus.Sub;
`endif

  // Next-state, datapath and output-register next values
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    work_nxt_s  = work_r;
    carry_nxt_s = carry_r;
    idx_nxt_s   = idx_r;
    s_nxt_s     = s_r;
    c_nxt_s     = c_r;
    v_nxt_s     = v_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          a_nxt_s     = bus.A;
          b_nxt_s     = b_load_s;
          carry_nxt_s = c_load_s;
          work_nxt_s  = {WIDTH{1'b0}};
          idx_nxt_s   = {IDX_W{1'b0}};
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        a_nxt_s     = a_r >> 1;
        b_nxt_s     = b_r >> 1;
        work_nxt_s  = {sum_s, work_r[WIDTH-1:1]};
        carry_nxt_s = cout_s;
        if (idx_r == LAST_IDX) begin
          // carry_r here is the carry into the MSB, cout_s the carry out of it
          s_nxt_s     = {sum_s, work_r[WIDTH-1:1]};
          c_nxt_s     = cout_s;
          v_nxt_s     = carry_r ^ cout_s;
          state_nxt_s = DONE;
        end else begin
          idx_nxt_s   = idx_r + IDX_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s == RUN);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // State, datapath and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      work_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      v_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      work_r  <= work_nxt_s;
      carry_r <= carry_nxt_s;
      idx_r   <= idx_nxt_s;
      s_r     <= s_nxt_s;
      c_r     <= c_nxt_s;
      v_r     <= v_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.S    = s_r;
  assign bus.C    = c_r;
  assign bus.V    = v_r;

endmodule

// File: tb/tb_serial_adder_decoder.sv
// Scoreboard bench for serial_adder_decoder: driver pushes expected results, monitor checks on done.
module tb_serial_adder_decoder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_run = 0;
  res_t exp_q[$];

  serial_adder_decoder_if #(.WIDTH(W)) bus ();

  serial_adder_decoder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int   ai, bi, ci, total, sa, sb, ss;
    ai = int'(a);
    bi = int'(b);
    ci = int'(cin);
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      bi = (1 << W) - 1 - int'(b);
      ci = 1;
    end
`endif
    total = ai + bi + ci;
    r.s = W'(total % (1 << W));
    r.c = (total >= (1 << W));
    sa = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
    sb = (bi >= (1 << (W - 1))) ? bi - (1 << W) : bi;
    ss = sa + sb + ci;
    r.v = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
    return r;
  endfunction

  // monitor: compare each done against the oldest expectation and check busy length
  initial begin
    res_t e, got;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run = 0;
      end else begin
        if (bus.busy) busy_run++;
        if (bus.done) begin
          got = {bus.S, bus.C, bus.V};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done got S=%h C=%b V=%b, required no done", bus.S, bus.C, bus.V);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL result got S=%h C=%b V=%b, required S=%h C=%b V=%b",
                       got.s, got.c, got.v, e.s, e.c, e.v);
            end
          end
          checks++;
          if (busy_run != W) begin
            errors++;
            $display("FAIL busy_cycles got %0d, required %0d", busy_run, W);
          end
          checks++;
          if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done got %b, required 0", bus.busy);
          end
          busy_run = 0;
        end
      end
    end
  end

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 40);
    checks++;
    if (!bus.done) begin
      errors++;
      $display("FAIL %s_timeout got no done in %0d cycles, required done", tag, n);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input res_t e);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
    bus.Sub = sub;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input res_t e, input string tag);
    start_op(a, b, cin, sub, e);
    wait_done(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           t0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
    bus.Sub = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.S, bus.C, bus.V} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b S=%h C=%b V=%b, required all 0",
               bus.busy, bus.done, bus.S, bus.C, bus.V);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, '{s: 8'h00, c: 1'b1, v: 1'b0}, "ff_plus_1");
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, '{s: 8'h80, c: 1'b0, v: 1'b1}, "overflow");
    run_op(8'h80, 8'h80, 1'b1, 1'b0, '{s: 8'h01, c: 1'b1, v: 1'b1}, "neg_overflow");
`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b1, '{s: 8'hFE, c: 1'b0, v: 1'b0}, "sub");
`else
    run_op(8'h05, 8'h07, 1'b1, 1'b1, '{s: 8'h0D, c: 1'b0, v: 1'b0}, "sub");
`endif

    // start during RUN must be ignored
    start_op(8'h10, 8'h20, 1'b1, 1'b0, '{s: 8'h31, c: 1'b0, v: 1'b0});
    repeat (2) @(negedge clk);
    bus.A = 8'h11;
    bus.B = 8'h22;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignored_start");

    // asynchronous abort mid-RUN
    start_op(8'h5A, 8'h33, 1'b0, 1'b0, '{s: 8'h8D, c: 1'b0, v: 1'b1});
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.S, bus.C, bus.V} !== '0) begin
      errors++;
      $display("FAIL abort_clear got busy=%b done=%b S=%h C=%b V=%b, required all 0",
               bus.busy, bus.done, bus.S, bus.C, bus.V);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, '{s: 8'h8D, c: 1'b0, v: 1'b1}, "after_abort");

    // back-to-back with start held high
    @(negedge clk);
    bus.A = 8'h01;
    bus.B = 8'h02;
    bus.Cin = 1'b0;
    bus.Sub = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    exp_q.push_back('{s: 8'h03, c: 1'b0, v: 1'b0});
    bus.A = 8'h03;
    bus.B = 8'h04;
    wait_done("b2b_first");
    checks++;
    if (cyc - t0 != W) begin
      errors++;
      $display("FAIL b2b_first_latency got %0d, required %0d", cyc - t0, W);
    end
    exp_q.push_back('{s: 8'h07, c: 1'b0, v: 1'b0});
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("b2b_second");
    checks++;
    if (cyc - t0 != 2 * W + 1) begin
      errors++;
      $display("FAIL b2b_second_latency got %0d, required %0d", cyc - t0, 2 * W + 1);
    end

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), "random");
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect got %0d pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
